anita3_event_buffer_sequencer: RTL
==================================

// Module: anita3_event_buffer_sequencer
// PURPOSE
//  Sequences the 4-deep event buffer RAM: allocates a free buffer per trigger, streams one
//  64-word 16-bit event from the digitizer source into it, then flags completion.
//  Tracks occupancy and the host read pointer, and gates host clears.
//  Counts triggers lost to deadtime or full buffers.
//  Sits between the trigger/digitizer path and the event buffer RAM, in the clk33 domain.
// PARAMETERS
//  NBUF_BITS  2   log2(number of event buffers); 4 buffers
//  WORD_BITS  6   log2(words per event); 64 x 16-bit words
//  LOST_BITS  16  width of the saturating lost-trigger counter
// PORTS
//  clk33_i          in   1   system clock, 33 MHz; the only clock
//  rst_n_i          in   1   asynchronous active-low reset
//  trig_i           in   1   trigger request, single-cycle pulse
//  src_dat_i        in   16  event word from digitizer
//  src_valid_i      in   1   src_dat_i valid
//  src_ready_o      out  1   sequencer accepts a word (handshake when valid & ready)
//  event_wr_addr_o  out  8   RAM write address {wr_buf[1:0], word[5:0]}
//  event_wr_dat_o   out  16  RAM write data
//  event_wr_o       out  1   RAM write strobe
//  event_done_o     out  1   1-cycle pulse: buffer event_wr_addr_o[7:6] is complete
//  clear_evt_i      in   1   host finished reading the current read buffer (pulse)
//  clear_evt_o      out  1   gated clear to RAM block: clear_evt_i & (count != 0), combinational
//  read_buffer_o    out  2   buffer the host reads next (rd_ptr)
//  event_ready_o    out  1   count != 0
//  buffer_full_o    out  1   count == 4
//  buffer_count_o   out  3   occupied buffers, 0..4
//  trig_lost_o      out  1   1-cycle pulse per rejected trigger
//  lost_count_o     out  16  rejected triggers, saturates at 0xFFFF
// BEHAVIOUR
//  Reset (async assert, sync release): all registers and outputs are 0.
//   state=IDLE, wr_ptr=rd_ptr=0, count=0, word=0, lost_count=0.
//  FSM, one transition per clock:
//   IDLE: trig_i & count<4  -> FILL; latch wr_buf=wr_ptr; word=0.
//         trig_i & count==4 -> stay IDLE; trig_lost_o=1 next cycle; lost_count+1.
//   FILL: src_ready_o=1 (registered, high for the whole state).
//         Each src_valid_i cycle accepts src_dat_i.
//         Accept of word k at cycle t: event_wr_o=1, event_wr_dat_o=word, and
//           event_wr_addr_o={wr_buf,k} at t+1.
//         Outside FILL write cycles event_wr_o=0.
//         After accepting word 63: src_ready_o=0 from t+1; -> DONE.
//   DONE: event_done_o=1 at t+2 with event_wr_addr_o held at {wr_buf,6'd63};
//         wr_ptr+1 (mod 4); count+1 -> IDLE.
//  trig_i in FILL or DONE: rejected as deadtime. trig_lost_o pulses; lost_count+1.
//   The FSM is unaffected.
//  lost_count saturates at 2^LOST_BITS-1; the pulse still fires.
//  clear_evt_i with count!=0: rd_ptr+1 (mod 4), count-1.
//  clear_evt_i with count==0: ignored; clear_evt_o stays 0.
//  Clear and completion in the same cycle: count unchanged; both pointers advance.
//  Completion when count==4 cannot occur (FILL only entered with count<4).
//  Reset mid-FILL: event aborted, no event_done_o, buffer not counted.
//  The RAM contents are don't-care.
//  Pointers wrap 3->0 with no special handling.
//  src_valid_i outside FILL: ignored; no write.
// TESTING
//  1 Reset then trig_i, 64 back-to-back valid words 0x0000..0x003F:
//    writes at addr 0x00..0x3F, last word at 0x3F.
//    event_done_o 1 cycle after last write, addr[7:6]=0.
//    count=1, event_ready_o=1.
//  2 Four events with no clear: buffer_full_o=1, count=4.
//    Fifth trig_i: trig_lost_o pulse, lost_count=1, no write.
//    After 1 clear: count=3, read_buffer_o=1.
//  3 Trigger, source stalls (valid low every other cycle):
//    exactly 64 writes, addresses contiguous.
//    trig_i mid-FILL -> lost_count+1; event completes normally.
//  4 clear_evt_i with count=0: clear_evt_o=0, read_buffer_o stays 0.
//    clear_evt_i in the same cycle as completion (count 1): count stays 1, rd_ptr+1.
//  5 Six fill/clear cycles: wr addr[7:6] sequence 0,1,2,3,0,1; read_buffer_o wraps 3->0.
//  6 rst_n_i low after word 20 of an event: outputs 0 immediately.
//    After release, the next trigger writes buffer 0 from addr 0x00.
//    Force lost_count to 0xFFFF: a further reject keeps 0xFFFF.

Source files
------------

// File: rtl/anita3_event_buffer_sequencer.sv
// Event buffer sequencer: allocates one of 2^NBUF_BITS buffers per trigger, streams one
// event into it, and tracks occupancy, the host read pointer and rejected triggers.
module anita3_event_buffer_sequencer #(
    parameter int unsigned NBUF_BITS = 2,
    parameter int unsigned WORD_BITS = 6,
    parameter int unsigned LOST_BITS = 16
) (
    input  logic                           clk33_i,
    input  logic                           rst_n_i,
    input  logic                           trig_i,
    input  logic [15:0]                    src_dat_i,
    input  logic                           src_valid_i,
    output logic                           src_ready_o,
    output logic [NBUF_BITS+WORD_BITS-1:0] event_wr_addr_o,
    output logic [15:0]                    event_wr_dat_o,
    output logic                           event_wr_o,
    output logic                           event_done_o,
    input  logic                           clear_evt_i,
    output logic                           clear_evt_o,
    output logic [NBUF_BITS-1:0]           read_buffer_o,
    output logic                           event_ready_o,
    output logic                           buffer_full_o,
    output logic [NBUF_BITS:0]             buffer_count_o,
    output logic                           trig_lost_o,
    output logic [LOST_BITS-1:0]           lost_count_o
);

    localparam int unsigned CW   = NBUF_BITS + 1;
    localparam int unsigned NBUF = 1 << NBUF_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   ready_q;
    logic [NBUF_BITS-1:0]   wr_buf_q, wr_ptr_q, rd_ptr_q;
    logic [WORD_BITS-1:0]   word_q;
    logic [NBUF_BITS+WORD_BITS-1:0] addr_q;
    logic [15:0]            dat_q;
    logic                   wr_q, done_q, lost_q;
    logic [CW-1:0]          count_q;
    logic [LOST_BITS-1:0]   lost_cnt_q;

    logic full, accept, last_word, complete, clr_ok, trig_reject, start;

    assign full        = (count_q == CW'(NBUF));
    assign accept      = (state_q == FILL) && ready_q && src_valid_i;
    assign last_word   = accept && (word_q == '1);
    assign complete    = (state_q == DONE);
    assign clr_ok      = clear_evt_i && (count_q != '0);
    // Triggers are only taken in IDLE with a free buffer; anything else is deadtime or overflow
    assign trig_reject = trig_i && ((state_q != IDLE) || full);
    assign start       = (state_q == IDLE) && (state_d == FILL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trig_i && !full) state_d = FILL;
            FILL:    if (last_word)       state_d = DONE;
            DONE:                         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            wr_buf_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            dat_q      <= '0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            lost_q     <= 1'b0;
            count_q    <= '0;
            lost_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == FILL);
            wr_q    <= accept;
            done_q  <= complete;
            lost_q  <= trig_reject;

            if (start) begin
                wr_buf_q <= wr_ptr_q;
                word_q   <= '0;
            end else if (accept) begin
                word_q <= word_q + WORD_BITS'(1);
            end

            if (accept) begin
                addr_q <= {wr_buf_q, word_q};
                dat_q  <= src_dat_i;
            end

            if (complete) wr_ptr_q <= wr_ptr_q + NBUF_BITS'(1);
            if (clr_ok)   rd_ptr_q <= rd_ptr_q + NBUF_BITS'(1);

            // Simultaneous completion and clear leave the occupancy unchanged
            case ({complete, clr_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            if (trig_reject && (lost_cnt_q != '1))
                lost_cnt_q <= lost_cnt_q + LOST_BITS'(1);
        end
    end

    assign src_ready_o     = ready_q;
    assign event_wr_addr_o = addr_q;
    assign event_wr_dat_o  = dat_q;
    assign event_wr_o      = wr_q;
    assign event_done_o    = done_q;
    assign clear_evt_o     = clr_ok;
    assign read_buffer_o   = rd_ptr_q;
    assign event_ready_o   = (count_q != '0);
    assign buffer_full_o   = full;
    assign buffer_count_o  = count_q;
    assign trig_lost_o     = lost_q;
    assign lost_count_o    = lost_cnt_q;

endmodule
